nes_apu_frame_sequencer: RTL
============================

Name: nes_apu_frame_sequencer

Overview:
Frame counter / sequencer for the NES APU datapath, equivalent to the $4017 frame counter. Counts APU ticks and issues the quarter-frame and half-frame strobes. Quarter-frame clocks the envelopes and the triangle linear counter. Half-frame clocks the length counters and sweep units. Also owns the frame IRQ flag that the $4015 status path reads and acknowledges.

Parameters:
STEP1, 3728, APU-tick count of sequencer step 1
STEP2, 7456, count of step 2
STEP3, 11185, count of step 3
STEP4, 14914, count of step 4; wrap point in 4-step mode
STEP5, 18640, count of step 5; wrap point in 5-step mode
CNT_W, 15, counter width; must hold STEP5

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
apu_tick  in  1  one-clk enable, once per APU cycle (CPU clock / 2)
reg_wr  in  1  one-clk write strobe for $4017
reg_wdata  in  8  write data; bit7 = mode (1 = 5-step), bit6 = IRQ inhibit, others ignored
irq_ack  in  1  one-clk pulse; $4015 read acknowledges the frame IRQ
quarter_frame  out  1  one-clk strobe
half_frame  out  1  one-clk strobe
frame_irq  out  1  level, frame interrupt flag
seq_mode  out  1  current mode bit (readback)

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - cnt = 0
  - mode = 0, inhibit = 0
  - frame_irq = 0, quarter_frame = 0, half_frame = 0
  - seq_mode = 0, reset_pending = 0
- Counting:
  - Counter cnt (CNT_W bits) changes only on apu_tick.
  - On a tick, if cnt equals the wrap point (STEP4 in 4-step mode, STEP5 in 5-step mode), cnt becomes 0. Otherwise cnt increments by 1.
- Step decode, evaluated on the tick using the pre-increment cnt:
  - 4-step mode: STEP1 -> QF; STEP2 -> QF+HF; STEP3 -> QF; STEP4 -> QF+HF, plus IRQ set if inhibit = 0.
  - 5-step mode: STEP1 -> QF; STEP2 -> QF+HF; STEP3 -> QF; STEP4 -> nothing; STEP5 -> QF+HF. No IRQ is ever set in 5-step mode.
- Strobe timing: the strobe outputs are registered. They assert for exactly one clk cycle, the cycle after the decoding tick. Latency is 1 clk. Strobes never stretch, even with apu_tick held high.
- $4017 write (reg_wr):
  - mode and inhibit latch from reg_wdata[7:6] on the write clock; seq_mode follows 1 clk later.
  - reset_pending is set.
  - If bit6 = 1, frame_irq clears on the next clk.
- Pending reset:
  - At the next apu_tick with reset_pending = 1: cnt becomes 0, reset_pending clears, and normal step decode is suppressed for that tick.
  - If mode = 1, QF+HF are strobed immediately.
  - A write arriving on the same clk as that apu_tick re-arms the pending reset; the newest write data wins.
- IRQ flag:
  - Set by a STEP4 match.
  - Cleared by irq_ack or by a write with inhibit = 1.
  - If set and clear coincide on the same clk, set wins.
  - While inhibit = 1 the flag cannot be set.
- Mid-operation reset: asserting rst_n low forces all reset values immediately, whatever the counter state.
- Arithmetic: unsigned, no saturation. cnt must never exceed the wrap point; any value above it (unreachable) wraps to 0 on the next tick.

Optional Feature:
NES_APU_FRAME_PAL_EN
- Defined: adds input port pal_sel (1 bit). While pal_sel = 1, the step constants become 4156, 8313, 12469, 16626 and 20782 (PAL 2A07 timing). While pal_sel = 0, the parameter values are used. A change of pal_sel takes effect on the next tick. If cnt is already past the new wrap point, it wraps to 0 on that tick.
- Undefined: there is no pal_sel port and only the parameter values are used.

Test Plan:
- Scaled parameters STEP1..5 = 4, 8, 12, 16, 20, mode 0, apu_tick every 2nd clk:
  - QF at ticks 4, 8, 12, 16; HF at ticks 8 and 16.
  - frame_irq rises 1 clk after tick 16.
  - Sequence repeats with period 17 ticks.
- Write 0x80 (5-step mode):
  - QF+HF strobe on the first tick after the write, with cnt = 0.
  - Then QF at 4, 8, 12 and HF at 8; nothing at 16; QF+HF at 20; period 21 ticks.
  - frame_irq stays 0 throughout.
- IRQ clearing, mode 0:
  - Let the IRQ set, then pulse irq_ack -> frame_irq = 0 next clk.
  - Let it set again, then write 0x40 -> clears, and stays 0 across further STEP4 matches.
- irq_ack on the same clk as the STEP4 registration -> frame_irq = 1 (set wins).
- Two writes (0x00, then 0x80) before a tick -> only 0x80 applies: one QF+HF strobe and seq_mode = 1.
- rst_n pulsed low at cnt = 10 -> all outputs 0 immediately; after release the first QF comes at tick 4.

Source files
------------

// File: rtl/nes_apu_frame_sequencer.sv
// rtl/nes_apu_frame_sequencer.sv - $4017 frame counter: quarter/half-frame strobes and frame IRQ
// Optional PAL step timing via NES_APU_FRAME_PAL_EN (adds pal_sel input).
module nes_apu_frame_sequencer #(
  parameter int STEP1 = 3728,
  parameter int STEP2 = 7456,
  parameter int STEP3 = 11185,
  parameter int STEP4 = 14914,
  parameter int STEP5 = 18640,
  parameter int CNT_W = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       apu_tick,
  input  logic       reg_wr,
  input  logic [7:0] reg_wdata,
  input  logic       irq_ack,
`ifdef NES_APU_FRAME_PAL_EN
  input  logic       pal_sel,
`endif
  output logic       quarter_frame,
  output logic       half_frame,
  output logic       frame_irq,
  output logic       seq_mode
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             inhibit_q, inhibit_d;
  logic             pending_q, pending_d;
  logic             qf_q, qf_d;
  logic             hf_q, hf_d;
  logic             irq_q, irq_d;
  logic             seq_mode_q, seq_mode_d;
  logic             irq_set;
  logic [CNT_W-1:0] s1, s2, s3, s4, s5, wrap;
  logic             unused_wdata;

  assign unused_wdata = ^reg_wdata[5:0];

  always_comb begin
`ifdef NES_APU_FRAME_PAL_EN
    if (pal_sel) begin
      s1 = CNT_W'(4156);
      s2 = CNT_W'(8313);
      s3 = CNT_W'(12469);
      s4 = CNT_W'(16626);
      s5 = CNT_W'(20782);
    end else begin
      s1 = CNT_W'(STEP1);
      s2 = CNT_W'(STEP2);
      s3 = CNT_W'(STEP3);
      s4 = CNT_W'(STEP4);
      s5 = CNT_W'(STEP5);
    end
`else
    s1 = CNT_W'(STEP1);
    s2 = CNT_W'(STEP2);
    s3 = CNT_W'(STEP3);
    s4 = CNT_W'(STEP4);
    s5 = CNT_W'(STEP5);
`endif
  end

  assign wrap = mode_q ? s5 : s4;

  always_comb begin
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    inhibit_d  = inhibit_q;
    pending_d  = pending_q;
    qf_d       = 1'b0;
    hf_d       = 1'b0;
    irq_d      = irq_q;
    irq_set    = 1'b0;
    seq_mode_d = mode_q;

    if (apu_tick) begin
      if (pending_q) begin
        // Deferred $4017 reset: restart the sequence; 5-step mode clocks units at once.
        cnt_d     = '0;
        pending_d = 1'b0;
        qf_d      = mode_q;
        hf_d      = mode_q;
      end else begin
        cnt_d = (cnt_q >= wrap) ? '0 : cnt_q + CNT_W'(1);
        if (cnt_q == s1 || cnt_q == s2 || cnt_q == s3) qf_d = 1'b1;
        if (cnt_q == s2) hf_d = 1'b1;
        if (!mode_q && cnt_q == s4) begin
          qf_d    = 1'b1;
          hf_d    = 1'b1;
          irq_set = !inhibit_q;
        end
        if (mode_q && cnt_q == s5) begin
          qf_d = 1'b1;
          hf_d = 1'b1;
        end
      end
    end

    if (reg_wr) begin
      mode_d    = reg_wdata[7];
      inhibit_d = reg_wdata[6];
      pending_d = 1'b1;
    end

    if (irq_ack || (reg_wr && reg_wdata[6])) irq_d = 1'b0;
    if (irq_set) irq_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      inhibit_q  <= 1'b0;
      pending_q  <= 1'b0;
      qf_q       <= 1'b0;
      hf_q       <= 1'b0;
      irq_q      <= 1'b0;
      seq_mode_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      inhibit_q  <= inhibit_d;
      pending_q  <= pending_d;
      qf_q       <= qf_d;
      hf_q       <= hf_d;
      irq_q      <= irq_d;
      seq_mode_q <= seq_mode_d;
    end
  end

  assign quarter_frame = qf_q;
  assign half_frame    = hf_q;
  assign frame_irq     = irq_q;
  assign seq_mode      = seq_mode_q;

endmodule
